reqack_demux_one2two: RTL and testbench
=======================================

Name: reqack_demux_one2two

Overview:
- Clocked 1-to-2 steering router for 4-phase req/ack bundled-data channels. It is the fork-side counterpart of the 2-to-1 arbiter.
- One producer hands over a data word plus a destination select. The block delivers the word to consumer 0 or consumer 1.
- Each consumer output holds a one-place buffer, so the producer handshake completes independently of consumer progress.
- Sits between one async producer and two async consumers. All incoming req/ack are synchronized into clk.

Parameters:
- DWIDTH, 1, width of the data word on every channel.

Ports:
- clk  input  1  sampling clock.
- rst_n  input  1  reset; asynchronous, active-low.
- prod_req  input  1  producer 4-phase request (async).
- prod_ack  output  1  producer acknowledge.
- prod_dat  input  DWIDTH  producer data; bundled with prod_req.
- prod_sel  input  1  destination: 0 = consumer 0, 1 = consumer 1; bundled with prod_req.
- cons0_req  output  1  consumer 0 request.
- cons0_ack  input  1  consumer 0 acknowledge (async).
- cons0_dat  output  DWIDTH  consumer 0 data.
- cons1_req  output  1  consumer 1 request.
- cons1_ack  input  1  consumer 1 acknowledge (async).
- cons1_dat  output  DWIDTH  consumer 1 data.

Behaviour:
- Reset: while rst_n=0, all of the following are 0, asynchronously: prod_ack, cons0_req, cons1_req, cons0_dat, cons1_dat, all synchronizer flops, all state. Reset mid-handshake abandons the transfer; no replay after reset release.
- Synchronizers: prod_req, cons0_ack and cons1_ack each pass through a 2-flop synchronizer reset to 0. Only the synchronized values (req_s, ack0_s, ack1_s) are used internally.
- Producer FSM:
  - P_IDLE (prod_ack=0) -> P_HOLD when accept fires.
  - P_HOLD (prod_ack=1) -> P_IDLE on the cycle req_s is 0.
  - prod_ack is registered.
- Accept condition: req_s=1 and prod_ack=0 and the channel addressed by prod_sel is in C_IDLE.
  - prod_sel and prod_dat are sampled on the accept edge and must be stable whenever prod_req=1 (bundled-data).
- Per-channel FSM (k = 0, 1):
  - C_IDLE: consk_req=0, ackk_s=0. Goes to C_REQ on an accept with sel=k. On that same edge, consk_dat <= prod_dat and consk_req <= 1.
  - C_REQ: consk_req=1. Goes to C_RET when ackk_s=1; consk_req <= 0 on that edge.
  - C_RET: consk_req=0, waiting for ackk_s=0. Goes to C_IDLE when ackk_s=0.
  - consk_dat holds its value outside accept edges.
- Latency:
  - prod_req rise to prod_ack/consk_req rise is 3 clk edges when the channel is idle: 2 sync edges + 1 register edge.
  - consk_ack rise to consk_req fall is 3 edges.
  - prod_req fall to prod_ack fall is 3 edges.
- Blocking:
  - If the addressed channel is not C_IDLE, the producer waits with prod_ack=0 until it is.
  - The other channel is never affected; there is no head-of-line bypass, and requests stay in order.
- Decoupling: after prod_ack falls, a new producer transfer to the other channel may be accepted while the first consumer is still in C_REQ/C_RET. Both consk_req may be 1 simultaneously.
- Simultaneous events: accept and a channel's ackk_s transitions cannot collide, because accept needs C_IDLE. Channel transitions on both channels in one cycle are independent.
- Glitch-free outputs: all outputs come directly from flops.
- Protocol errors: a consumer raising ack with consk_req=0 while in C_IDLE is ignored. The block stays in C_IDLE until ackk_s falls, and accepts to that channel are blocked while ackk_s=1.

Test Plan:
- Reset then single transfer: DWIDTH=8, prod_sel=0, prod_dat=8'hA5, raise prod_req -> cons0_req=1 and cons0_dat=8'hA5 exactly 3 edges later, prod_ack=1 on the same edge. cons1_req stays 0 and cons1_dat stays 8'h00.
- Full 4-phase on consumer 1: sel=1, dat=8'h3C; consumer acks, producer drops req -> cons1_req falls 3 edges after cons1_ack rise, prod_ack falls 3 edges after prod_req fall, and the block returns to idle.
- Blocking: consumer 0 holds ack low; send 8'h11 to ch0, then 8'h22 to ch0 -> the second prod_ack stays 0 until consumer 0 completes. cons0_dat shows 8'h11 and then 8'h22.
- Decoupling: send 8'h11 to ch0 (consumer 0 stalled), then 8'h22 to ch1 -> the second transfer is acked. cons0_req and cons1_req are both 1 with correct data.
- Async reset mid-transfer: pulse rst_n low while cons1_req=1 and prod_ack=1 -> all outputs go to 0 immediately, with no spurious cons*_req after release.
- Random stress: 1000 transfers with random sel/dat and random consumer ack delays of 0-20 cycles -> every word is delivered exactly once, in order per channel, with no loss or duplication.

Source files
------------

// File: rtl/reqack_demux_one2two.sv
// 1-to-2 steering router for 4-phase req/ack bundled-data channels.
// One producer word is delivered into a one-place buffer on consumer 0 or 1.
module reqack_demux_one2two #(
   parameter int DWIDTH = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prod_req,
   output logic              prod_ack,
   input  logic [DWIDTH-1:0] prod_dat,
   input  logic              prod_sel,
   output logic              cons0_req,
   input  logic              cons0_ack,
   output logic [DWIDTH-1:0] cons0_dat,
   output logic              cons1_req,
   input  logic              cons1_ack,
   output logic [DWIDTH-1:0] cons1_dat,
   output logic [4:0]        o_dbg_state
);

   typedef enum logic {P_IDLE = 1'b0, P_HOLD = 1'b1} p_state_t;
   typedef enum logic [1:0] {C_IDLE = 2'd0, C_REQ = 2'd1, C_RET = 2'd2} c_state_t;

   logic              r_req_m, r_req_s;
   logic              r_ack0_m, r_ack0_s;
   logic              r_ack1_m, r_ack1_s;
   p_state_t          r_p_state;
   logic              r_prod_ack;
   c_state_t          r_c_state [2];
   logic              r_cons_req [2];
   logic [DWIDTH-1:0] r_cons_dat [2];

   logic              w_ack_s [2];
   logic              w_ch_free [2];
   logic              w_accept;

   // A channel is free only when idle and its consumer has released ack;
   // a stray ack raised while idle blocks the channel until it drops.
   always_comb begin
      w_ack_s[0]   = r_ack0_s;
      w_ack_s[1]   = r_ack1_s;
      w_ch_free[0] = (r_c_state[0] == C_IDLE) && !r_ack0_s;
      w_ch_free[1] = (r_c_state[1] == C_IDLE) && !r_ack1_s;
      w_accept     = r_req_s && !r_prod_ack && w_ch_free[prod_sel];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_m    <= 1'b0;
         r_req_s    <= 1'b0;
         r_ack0_m   <= 1'b0;
         r_ack0_s   <= 1'b0;
         r_ack1_m   <= 1'b0;
         r_ack1_s   <= 1'b0;
         r_p_state  <= P_IDLE;
         r_prod_ack <= 1'b0;
         for (int k = 0; k < 2; k++) begin
            r_c_state[k]  <= C_IDLE;
            r_cons_req[k] <= 1'b0;
            r_cons_dat[k] <= '0;
         end
      end else begin
         r_req_m  <= prod_req;
         r_req_s  <= r_req_m;
         r_ack0_m <= cons0_ack;
         r_ack0_s <= r_ack0_m;
         r_ack1_m <= cons1_ack;
         r_ack1_s <= r_ack1_m;

         case (r_p_state)
            P_IDLE: if (w_accept) begin
               r_p_state  <= P_HOLD;
               r_prod_ack <= 1'b1;
            end
            P_HOLD: if (!r_req_s) begin
               r_p_state  <= P_IDLE;
               r_prod_ack <= 1'b0;
            end
            default: begin
               r_p_state  <= P_IDLE;
               r_prod_ack <= 1'b0;
            end
         endcase

         for (int k = 0; k < 2; k++) begin
            case (r_c_state[k])
               C_IDLE: if (w_accept && (prod_sel == 1'(k))) begin
                  r_c_state[k]  <= C_REQ;
                  r_cons_req[k] <= 1'b1;
                  r_cons_dat[k] <= prod_dat;
               end
               C_REQ: if (w_ack_s[k]) begin
                  r_c_state[k]  <= C_RET;
                  r_cons_req[k] <= 1'b0;
               end
               C_RET: if (!w_ack_s[k]) begin
                  r_c_state[k] <= C_IDLE;
               end
               default: begin
                  r_c_state[k]  <= C_IDLE;
                  r_cons_req[k] <= 1'b0;
               end
            endcase
         end
      end
   end

   assign prod_ack    = r_prod_ack;
   assign cons0_req   = r_cons_req[0];
   assign cons1_req   = r_cons_req[1];
   assign cons0_dat   = r_cons_dat[0];
   assign cons1_dat   = r_cons_dat[1];
   assign o_dbg_state = {r_c_state[1], r_c_state[0], r_p_state};

endmodule

// File: tb/tb_reqack_demux_one2two.sv
// Directed and randomized-delay checks for the 1-to-2 req/ack router.
// Handshake rule: a word moves when req rises and is acked; req falls, then ack falls.
module tb_reqack_demux_one2two;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       prod_req = 1'b0;
   logic       prod_ack;
   logic [7:0] prod_dat = 8'h00;
   logic       prod_sel = 1'b0;
   logic       cons0_req, cons1_req;
   logic       cons0_ack, cons1_ack;
   logic [7:0] cons0_dat, cons1_dat;
   logic [4:0] dbg_state;

   logic       auto0 = 1'b0, auto1 = 1'b0;
   logic       man_ack0 = 1'b0, man_ack1 = 1'b0;
   logic       auto_ack0 = 1'b0, auto_ack1 = 1'b0;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   int         n_vec = 0;
   int         n_err = 0;

   assign cons0_ack = auto0 ? auto_ack0 : man_ack0;
   assign cons1_ack = auto1 ? auto_ack1 : man_ack1;

   reqack_demux_one2two #(.DWIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .prod_req(prod_req), .prod_ack(prod_ack), .prod_dat(prod_dat), .prod_sel(prod_sel),
      .cons0_req(cons0_req), .cons0_ack(cons0_ack), .cons0_dat(cons0_dat),
      .cons1_req(cons1_req), .cons1_ack(cons1_ack), .cons1_dat(cons1_dat),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " prod_ack"},  32'(prod_ack),  32'h0);
      check({tag, " cons0_req"}, 32'(cons0_req), 32'h0);
      check({tag, " cons1_req"}, 32'(cons1_req), 32'h0);
      check({tag, " cons0_dat"}, 32'(cons0_dat), 32'h0);
      check({tag, " cons1_dat"}, 32'(cons1_dat), 32'h0);
   endtask

   // Producer side of one full 4-phase transfer, with bounded waits.
   task automatic send(input logic sel, input logic [7:0] dat, input int limit);
      int i;
      prod_sel = sel;
      prod_dat = dat;
      prod_req = 1'b1;
      i = 0;
      while (prod_ack !== 1'b1 && i < limit) begin tick(1); i++; end
      check("send ack rise", 32'(prod_ack), 32'h1);
      prod_req = 1'b0;
      i = 0;
      while (prod_ack !== 1'b0 && i < 10) begin tick(1); i++; end
      check("send ack fall", 32'(prod_ack), 32'h0);
   endtask

   // Automatic consumer 0: scoreboard the word, ack after a random delay.
   initial forever begin
      int d, i;
      logic [7:0] e;
      @(negedge clk);
      if (auto0 && cons0_req === 1'b1) begin
         e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
         check("ch0 data order", 32'(cons0_dat), 32'(e));
         d = $urandom_range(0, 20);
         repeat (d) @(negedge clk);
         auto_ack0 = 1'b1;
         i = 0;
         while (cons0_req !== 1'b0 && i < 10) begin @(negedge clk); i++; end
         check("ch0 req fall", 32'(cons0_req), 32'h0);
         auto_ack0 = 1'b0;
      end
   end

   initial forever begin
      int d, i;
      logic [7:0] e;
      @(negedge clk);
      if (auto1 && cons1_req === 1'b1) begin
         e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'hxx;
         check("ch1 data order", 32'(cons1_dat), 32'(e));
         d = $urandom_range(0, 20);
         repeat (d) @(negedge clk);
         auto_ack1 = 1'b1;
         i = 0;
         while (cons1_req !== 1'b0 && i < 10) begin @(negedge clk); i++; end
         check("ch1 req fall", 32'(cons1_req), 32'h0);
         auto_ack1 = 1'b0;
      end
   end

   initial begin
      logic       s;
      logic [7:0] v;
      int         i;

      // Reset state
      tick(3);
      check_all_zero("in reset");
      rst_n = 1'b1;
      tick(2);
      check("idle state", 32'(dbg_state), 32'h0);

      // Single transfer to ch0: 3-edge latency
      prod_sel = 1'b0; prod_dat = 8'hA5; prod_req = 1'b1;
      tick(2);
      check("t1 req early", 32'(cons0_req), 32'h0);
      check("t1 ack early", 32'(prod_ack), 32'h0);
      tick(1);
      check("t1 cons0_req", 32'(cons0_req), 32'h1);
      check("t1 prod_ack", 32'(prod_ack), 32'h1);
      check("t1 cons0_dat", 32'(cons0_dat), 32'hA5);
      check("t1 cons1_req", 32'(cons1_req), 32'h0);
      check("t1 cons1_dat", 32'(cons1_dat), 32'h00);
      prod_req = 1'b0; man_ack0 = 1'b1;
      tick(2);
      check("t1 ack hold", 32'(prod_ack), 32'h1);
      check("t1 req hold", 32'(cons0_req), 32'h1);
      tick(1);
      check("t1 ack fall", 32'(prod_ack), 32'h0);
      check("t1 req fall", 32'(cons0_req), 32'h0);
      man_ack0 = 1'b0;
      tick(3);
      check("t1 back idle", 32'(dbg_state), 32'h0);
      check("t1 dat held", 32'(cons0_dat), 32'hA5);

      // Full 4-phase on ch1
      prod_sel = 1'b1; prod_dat = 8'h3C; prod_req = 1'b1;
      tick(3);
      check("t2 cons1_req", 32'(cons1_req), 32'h1);
      check("t2 cons1_dat", 32'(cons1_dat), 32'h3C);
      man_ack1 = 1'b1;
      tick(2);
      check("t2 req hold", 32'(cons1_req), 32'h1);
      tick(1);
      check("t2 req fall", 32'(cons1_req), 32'h0);
      prod_req = 1'b0;
      tick(2);
      check("t2 ack hold", 32'(prod_ack), 32'h1);
      tick(1);
      check("t2 ack fall", 32'(prod_ack), 32'h0);
      man_ack1 = 1'b0;
      tick(3);
      check("t2 back idle", 32'(dbg_state), 32'h0);

      // Blocking on a busy channel
      send(1'b0, 8'h11, 10);
      check("t3 first dat", 32'(cons0_dat), 32'h11);
      prod_sel = 1'b0; prod_dat = 8'h22; prod_req = 1'b1;
      tick(10);
      check("t3 blocked ack", 32'(prod_ack), 32'h0);
      check("t3 dat kept", 32'(cons0_dat), 32'h11);
      man_ack0 = 1'b1;
      tick(3);
      check("t3 req fall", 32'(cons0_req), 32'h0);
      man_ack0 = 1'b0;
      tick(3);
      check("t3 still blocked", 32'(prod_ack), 32'h0);
      tick(1);
      check("t3 second ack", 32'(prod_ack), 32'h1);
      check("t3 second dat", 32'(cons0_dat), 32'h22);
      check("t3 second req", 32'(cons0_req), 32'h1);
      prod_req = 1'b0; man_ack0 = 1'b1;
      tick(3);
      man_ack0 = 1'b0;
      tick(3);
      check("t3 back idle", 32'(dbg_state), 32'h0);

      // Decoupling: ch0 stalled, ch1 still accepted
      send(1'b0, 8'h11, 10);
      prod_sel = 1'b1; prod_dat = 8'h22; prod_req = 1'b1;
      tick(3);
      check("t4 prod_ack", 32'(prod_ack), 32'h1);
      check("t4 cons0_req", 32'(cons0_req), 32'h1);
      check("t4 cons1_req", 32'(cons1_req), 32'h1);
      check("t4 cons0_dat", 32'(cons0_dat), 32'h11);
      check("t4 cons1_dat", 32'(cons1_dat), 32'h22);

      // Asynchronous reset mid-transfer
      #2 rst_n = 1'b0;
      #1 check_all_zero("async rst");
      prod_req = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(6);
      check_all_zero("after rst");
      check("rst idle", 32'(dbg_state), 32'h0);

      // Stray ack in idle blocks that channel until it drops
      man_ack1 = 1'b1;
      tick(3);
      prod_sel = 1'b1; prod_dat = 8'h5A; prod_req = 1'b1;
      tick(6);
      check("stray ack blocks", 32'(prod_ack), 32'h0);
      check("stray no req", 32'(cons1_req), 32'h0);
      man_ack1 = 1'b0;
      tick(3);
      check("stray released ack", 32'(prod_ack), 32'h1);
      check("stray released dat", 32'(cons1_dat), 32'h5A);
      prod_req = 1'b0; man_ack1 = 1'b1;
      tick(3);
      man_ack1 = 1'b0;
      tick(4);

      // Random stress with automatic consumers
      auto0 = 1'b1; auto1 = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         s = 1'($urandom_range(0, 1));
         v = 8'($urandom_range(0, 255));
         if (s) exp_q1.push_back(v); else exp_q0.push_back(v);
         send(s, v, 200);
      end
      i = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0 || cons0_req || cons1_req
              || cons0_ack || cons1_ack) && i < 500) begin tick(1); i++; end
      tick(6);
      check("stress q0 drained", 32'(exp_q0.size()), 32'h0);
      check("stress q1 drained", 32'(exp_q1.size()), 32'h0);
      check("stress end idle", 32'(dbg_state), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
